// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_arbiter_pkg: command encodings and address width shared by the cache modules
package cache_bus_arbiter_pkg;
    localparam int ADDR_W_DEF = 26;
    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_INVAL = 2'b11
    } cmd_e;
endpackage

// File: rtl/cache_bus_arbiter_req_fifo.sv
// req_fifo: power-of-two request queue with registered occupancy and a combinational head
module req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q  <= pop_i ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: merges I- and D-cache request queues round-robin into one registered output
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_cmd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    input  logic [1:0]        d_cmd,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ready,
    output logic [1:0]        cmd_out,
    output logic [ADDR_W-1:0] add_out,
    input  logic              out_ready,
    output logic [31:0]       grants_i,
    output logic [31:0]       grants_d,
    output logic [31:0]       conflicts
);
    localparam int W  = ADDR_W + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [CW-1:0] i_cnt, d_cnt;
    logic [W-1:0]  i_head, d_head;
    logic [W-1:0]  out_q, out_d;
    logic          prio_d_q, prio_d_d;
    logic [31:0]   grants_i_q, grants_i_d, grants_d_q, grants_d_d, conflicts_q, conflicts_d;
    logic          i_push, d_push, i_avail, d_avail, sel_i, sel_d, load, grant_i, grant_d;
    assign i_ready = i_cnt < CW'(FIFO_DEPTH);
    assign d_ready = d_cnt < CW'(FIFO_DEPTH);
    assign i_push  = (i_cmd != CMD_NOP) && i_ready;
    assign d_push  = (d_cmd != CMD_NOP) && d_ready;
    assign i_avail = i_cnt != '0;
    assign d_avail = d_cnt != '0;
    // prio_d_q set means I was granted last, so D wins the next tie
    assign sel_i   = i_avail && (!d_avail || !prio_d_q);
    assign sel_d   = d_avail && !sel_i;
    assign load    = (out_q[W-1 -: 2] == CMD_NOP) || out_ready;
    assign grant_i = load && sel_i;
    assign grant_d = load && sel_d;
    req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_i_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(i_push), .pop_i(grant_i),
        .data_i({i_cmd, i_addr}), .head_o(i_head), .count_o(i_cnt)
    );
    req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_d_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(d_push), .pop_i(grant_d),
        .data_i({d_cmd, d_addr}), .head_o(d_head), .count_o(d_cnt)
    );
    always_comb begin
        out_d       = !load ? out_q : grant_i ? i_head : grant_d ? d_head : '0;
        prio_d_d    = grant_i ? 1'b1 : grant_d ? 1'b0 : prio_d_q;
        grants_i_d  = grants_i_q + {31'd0, grant_i};
        grants_d_d  = grants_d_q + {31'd0, grant_d};
        conflicts_d = conflicts_q + {31'd0, load && i_avail && d_avail};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            prio_d_q    <= 1'b0;
            grants_i_q  <= '0;
            grants_d_q  <= '0;
            conflicts_q <= '0;
        end else begin
            out_q       <= out_d;
            prio_d_q    <= prio_d_d;
            grants_i_q  <= grants_i_d;
            grants_d_q  <= grants_d_d;
            conflicts_q <= conflicts_d;
        end
    end
    assign cmd_out   = out_q[W-1 -: 2];
    assign add_out   = out_q[ADDR_W-1:0];
    assign grants_i  = grants_i_q;
    assign grants_d  = grants_d_q;
    assign conflicts = conflicts_q;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: directed scenario tasks with hand-computed expectations
module tb_cache_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_cmd = 2'b00, d_cmd = 2'b00;
    logic [25:0] i_addr = '0, d_addr = '0;
    logic        out_ready = 1'b1;
    logic        i_ready, d_ready;
    logic [1:0]  cmd_out;
    logic [25:0] add_out;
    logic [31:0] grants_i, grants_d, conflicts;
    int checks = 0;
    int errors = 0;

    cache_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd(i_cmd), .i_addr(i_addr), .i_ready(i_ready),
        .d_cmd(d_cmd), .d_addr(d_addr), .d_ready(d_ready),
        .cmd_out(cmd_out), .add_out(add_out), .out_ready(out_ready),
        .grants_i(grants_i), .grants_d(grants_d), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_cmd = 2'b00;
        d_cmd = 2'b00;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b00 || add_out !== 26'h0) begin
            errors++;
            $display("FAIL reset_out: got cmd=%b addr=%h exp cmd=00 addr=0", cmd_out, add_out);
        end
        checks++;
        if (grants_i !== 32'd0 || grants_d !== 32'd0 || conflicts !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h exp 0 0 0", grants_i, grants_d, conflicts);
        end
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got i=%b d=%b exp 1 1", i_ready, d_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        i_cmd = 2'b01;
        i_addr = 26'h0000123;
        @(negedge clk);
        i_cmd = 2'b00;
        checks++;
        if (cmd_out !== 2'b00) begin
            errors++;
            $display("FAIL single_not_early: got cmd=%b exp 00", cmd_out);
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b01 || add_out !== 26'h0000123 || grants_i !== 32'd1) begin
            errors++;
            $display("FAIL single_load: got cmd=%b addr=%h gi=%0d exp 01 0000123 1", cmd_out, add_out, grants_i);
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b00 || add_out !== 26'h0 || grants_i !== 32'd1) begin
            errors++;
            $display("FAIL single_drain: got cmd=%b addr=%h gi=%0d exp 00 0 1", cmd_out, add_out, grants_i);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        i_cmd = 2'b01; i_addr = 26'h0000010;
        d_cmd = 2'b01; d_addr = 26'h0000020;
        @(negedge clk);
        i_cmd = 2'b00; d_cmd = 2'b00;
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b01 || add_out !== 26'h0000010 || conflicts !== 32'd1) begin
            errors++;
            $display("FAIL conflict_first: got cmd=%b addr=%h cf=%0d exp 01 0000010 1", cmd_out, add_out, conflicts);
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b01 || add_out !== 26'h0000020) begin
            errors++;
            $display("FAIL conflict_second: got cmd=%b addr=%h exp 01 0000020", cmd_out, add_out);
        end
        checks++;
        if (grants_i !== 32'd1 || grants_d !== 32'd1 || conflicts !== 32'd1) begin
            errors++;
            $display("FAIL conflict_counts: got gi=%0d gd=%0d cf=%0d exp 1 1 1", grants_i, grants_d, conflicts);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        i_cmd = 2'b10; i_addr = 26'h0000100;
        @(negedge clk);
        i_addr = 26'h0000101;
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b10 || add_out !== 26'h0000100 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: got cmd=%b addr=%h rdy=%b exp 10 0000100 1", cmd_out, add_out, i_ready);
        end
        i_addr = 26'h0000102;
        @(negedge clk);
        i_addr = 26'h0000103;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (i_ready !== 1'b0 || cmd_out !== 2'b10 || add_out !== 26'h0000100) begin
                errors++;
                $display("FAIL stall_hold%0d: got rdy=%b cmd=%b addr=%h exp 0 10 0000100", k, i_ready, cmd_out, add_out);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b10 || add_out !== 26'h0000101 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got cmd=%b addr=%h rdy=%b exp 10 0000101 1", cmd_out, add_out, i_ready);
        end
        @(negedge clk);
        i_cmd = 2'b00;
        checks++;
        if (add_out !== 26'h0000102) begin
            errors++;
            $display("FAIL stall_third: got addr=%h exp 0000102", add_out);
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b10 || add_out !== 26'h0000103 || grants_i !== 32'd4) begin
            errors++;
            $display("FAIL stall_fourth: got cmd=%b addr=%h gi=%0d exp 10 0000103 4", cmd_out, add_out, grants_i);
        end
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b00) begin
            errors++;
            $display("FAIL stall_empty: got cmd=%b exp 00", cmd_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_cmd = 2'b01; i_addr = 26'h00001AA;
        d_cmd = 2'b10; d_addr = 26'h00002BB;
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (cmd_out !== ((j % 2 == 0) ? 2'b01 : 2'b10) ||
                add_out !== ((j % 2 == 0) ? 26'h00001AA : 26'h00002BB) ||
                conflicts !== 32'(j + 1) || grants_i !== 32'(j / 2 + 1)) begin
                errors++;
                $display("FAIL alternate%0d: got cmd=%b addr=%h cf=%0d gi=%0d exp cmd=%b cf=%0d gi=%0d",
                         j, cmd_out, add_out, conflicts, grants_i, (j % 2 == 0) ? 2'b01 : 2'b10, j + 1, j / 2 + 1);
            end
            @(negedge clk);
        end
        i_cmd = 2'b00;
        d_cmd = 2'b00;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        i_cmd = 2'b01; i_addr = 26'h000003C;
        d_cmd = 2'b10; d_addr = 26'h000003D;
        repeat (4) @(negedge clk);
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0 || cmd_out !== 2'b01 || grants_i !== 32'd1) begin
            errors++;
            $display("FAIL full_before_reset: got ri=%b rd=%b cmd=%b gi=%0d exp 0 0 01 1", i_ready, d_ready, cmd_out, grants_i);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_out !== 2'b00 || add_out !== 26'h0 || i_ready !== 1'b1 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_out: got cmd=%b addr=%h ri=%b rd=%b exp 00 0 1 1", cmd_out, add_out, i_ready, d_ready);
        end
        checks++;
        if (grants_i !== 32'd0 || grants_d !== 32'd0 || conflicts !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_counters: got %h %h %h exp 0 0 0", grants_i, grants_d, conflicts);
        end
        @(negedge clk);
        i_cmd = 2'b00; d_cmd = 2'b00; out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cmd_out !== 2'b00 || grants_i !== 32'd0 || grants_d !== 32'd0) begin
            errors++;
            $display("FAIL no_replay: got cmd=%b gi=%0d gd=%0d exp 00 0 0", cmd_out, grants_i, grants_d);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.grants_i_q = 32'hFFFF_FFFF;
        #1 release dut.grants_i_q;
        i_cmd = 2'b01; i_addr = 26'h0000001;
        @(negedge clk);
        i_addr = 26'h0000002;
        @(negedge clk);
        i_cmd = 2'b00;
        checks++;
        if (grants_i !== 32'h0000_0000 || add_out !== 26'h0000001) begin
            errors++;
            $display("FAIL wrap_first: got gi=%h addr=%h exp 00000000 0000001", grants_i, add_out);
        end
        @(negedge clk);
        checks++;
        if (grants_i !== 32'h0000_0001 || add_out !== 26'h0000002) begin
            errors++;
            $display("FAIL wrap_second: got gi=%h addr=%h exp 00000001 0000002", grants_i, add_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, meaning line-address width (add_in[31:6]).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per requester queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_cmd  input  2  and i_addr  input  ADDR_W: instruction-cache request; a request is present when i_cmd != NOP.
REQ-006 SHALL have port i_ready  output  1  instruction queue can accept.
REQ-007 SHALL have ports d_cmd  input  2,  d_addr  input  ADDR_W  and  d_ready  output  1: same meaning for the data cache.
REQ-008 SHALL have ports cmd_out  output  2  and  add_out  output  ADDR_W: request to the next-level cache.
REQ-009 SHALL have port out_ready  input  1  next level accepts cmd_out/add_out this cycle.
REQ-010 SHALL have ports grants_i, grants_d, conflicts  output  32 each: statistics counters.

Function
REQ-011 SHALL use cmd encoding NOP=00, READ=01, WRITE=10, INVAL=11.
REQ-012 SHALL write {cmd,addr} into the requester's FIFO on a rising edge when cmd != NOP and that port's ready is 1.
REQ-013 SHALL drive i_ready/d_ready = 1 iff the registered occupancy of that FIFO < FIFO_DEPTH; a same-cycle pop does not free space for a same-cycle push.
REQ-014 SHALL hold a single output register; it is "valid" iff cmd_out != NOP.
REQ-015 SHALL complete a transfer on an edge where cmd_out != NOP and out_ready = 1.
REQ-016 SHALL load the output register from a FIFO head on an edge where the register is empty or is completing a transfer; otherwise cmd_out/add_out are held stable.
REQ-017 SHALL, with both heads non-empty at load, grant round-robin: the port not granted last; after reset the I port wins first.
REQ-018 SHALL, with one head non-empty, grant that port regardless of the round-robin pointer, and update the pointer to that port.
REQ-019 SHALL, with the register emptied and no heads available, drive cmd_out = NOP and add_out = 0.
REQ-020 SHALL give minimum latency of 1 cycle: a request pushed at edge N appears on cmd_out after edge N+1.
REQ-021 SHALL preserve per-port ordering (FIFO), with no ordering guarantee across ports.
REQ-022 SHALL increment grants_i/grants_d by 1 per load from that port and conflicts by 1 per load with both heads non-empty; all wrap modulo 2^32.
REQ-023 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH, with occupancy held at 0..FIFO_DEPTH; simultaneous push and pop leaves occupancy unchanged.

Reset
REQ-024 SHALL, while rst_n = 0, immediately clear FIFOs (occupancy 0), set cmd_out = NOP, add_out = 0, all counters 0, round-robin pointer to favour I, and drive i_ready = d_ready = 1.
REQ-025 SHALL discard in-flight and queued requests on reset mid-operation; nothing is replayed.

Structure
REQ-026 SHALL place cmd encodings (NOP/READ/WRITE/INVAL) and the ADDR_W default in a shared package used by cache modules and this block.
REQ-027 SHALL instantiate one sub-module, req_fifo (parameterised depth/width, push/pop/count/head), twice.

Verification
REQ-028 SHALL cover: reset, then I READ 0x0000123 with out_ready=1 -> cmd_out=01, add_out=0x0000123 one cycle after push, grants_i=1.
REQ-029 SHALL cover: I and D READ pushed same edge, out_ready=1 -> I granted first, D next cycle; conflicts=1, grants_i=grants_d=1.
REQ-030 SHALL cover: out_ready=0, three I pushes -> i_ready=0 after two queued plus one in register; third is held until space; cmd_out/add_out stable throughout.
REQ-031 SHALL cover: continuous I and D streams, out_ready=1 -> strict alternation I,D,I,D; conflicts increments each grant.
REQ-032 SHALL cover: rst_n asserted asynchronously mid-stall with queues full -> cmd_out=NOP, counters 0, readies 1 before next clk edge.
REQ-033 SHALL cover: grants_i preloaded near 0xFFFFFFFF via force, two grants -> wraps to 0x00000001.
